// File: rtl/score_bcd_counter.sv
// rtl/score_bcd_counter.sv - level-scaled packed-BCD score accumulator with saturating single-edge commit
//
// Accepts line-clear events, adds the base points (L+1) times one BCD digit
// per cycle into a private working copy, then publishes the result to
// score_out on a single commit edge so the renderer never sees a partial sum.
//
// Ports:
//   clk        system clock
//   rst        synchronous active-high reset
//   new_game   synchronous score clear, aborts any in-flight addition
//   add_valid  event request (held by the producer until add_ready)
//   add_lines  lines cleared, 1..4 valid, others dropped
//   level      current level, clamped to 9
//   add_ready  combinational: block can accept an event this cycle
//   score_out  committed packed-BCD score, thousands..units
//   score_upd  one-cycle pulse after score_out changes or is cleared
//   saturated  score_out == SAT_VALUE
module score_bcd_counter #(
    parameter logic [15:0] SAT_VALUE = 16'h9999
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        new_game,
    input  logic        add_valid,
    input  logic [2:0]  add_lines,
    input  logic [3:0]  level,
    output logic        add_ready,
    output logic [15:0] score_out,
    output logic        score_upd,
    output logic        saturated
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ADD    = 2'd1,
        COMMIT = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] pts_q, pts_d;
    logic [3:0]  rep_q, rep_d;
    logic [15:0] acc_q, acc_d;
    logic [1:0]  dig_q, dig_d;
    logic        cy_q, cy_d;
    logic [15:0] score_q, score_d;
    logic        upd_q, upd_d;
    logic        sat_q, sat_d;

    logic [15:0] base_pts;
    logic        lines_ok;
    logic [3:0]  lvl_clamped;
    logic        accept;
    logic [3:0]  nib_idx;
    logic [4:0]  dsum;
    logic        dcarry;
    logic [3:0]  dnew;
    logic [15:0] acc_sum;

    assign add_ready = (state_q == IDLE) && !new_game && !rst;
    assign accept    = add_valid && add_ready;

    assign score_out = score_q;
    assign score_upd = upd_q;
    assign saturated = sat_q;

    always_comb begin
        base_pts = 16'h0000;
        case (add_lines)
            3'd1:    base_pts = 16'h0040;
            3'd2:    base_pts = 16'h0100;
            3'd3:    base_pts = 16'h0300;
            3'd4:    base_pts = 16'h1200;
            default: base_pts = 16'h0000;
        endcase
    end

    assign lines_ok    = (add_lines != 3'd0) && (add_lines <= 3'd4);
    assign lvl_clamped = (level > 4'd9) ? 4'd9 : level;

    // One BCD digit of acc + pts + carry; acc_sum is acc with that digit replaced.
    always_comb begin
        nib_idx = {dig_q, 2'b00};
        dsum    = {1'b0, acc_q[nib_idx +: 4]} + {1'b0, pts_q[nib_idx +: 4]} + {4'b0000, cy_q};
        dcarry  = (dsum > 5'd9);
        // dsum is 10..19 when dcarry, so the 4-bit wrap of dsum[3:0]-10 is exact
        dnew    = dcarry ? (dsum[3:0] - 4'd10) : dsum[3:0];
        acc_sum = acc_q;
        acc_sum[nib_idx +: 4] = dnew;
    end

    always_comb begin
        state_d = state_q;
        pts_d   = pts_q;
        rep_d   = rep_q;
        acc_d   = acc_q;
        dig_d   = dig_q;
        cy_d    = cy_q;
        score_d = score_q;
        upd_d   = 1'b0;
        sat_d   = sat_q;

        if (new_game) begin
            state_d = IDLE;
            pts_d   = 16'h0000;
            rep_d   = 4'd0;
            acc_d   = 16'h0000;
            dig_d   = 2'd0;
            cy_d    = 1'b0;
            score_d = 16'h0000;
            sat_d   = 1'b0;
            upd_d   = 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept && lines_ok) begin
                        pts_d   = base_pts;
                        rep_d   = lvl_clamped;
                        acc_d   = score_q;
                        dig_d   = 2'd0;
                        cy_d    = 1'b0;
                        state_d = ADD;
                    end
                end
                ADD: begin
                    acc_d = acc_sum;
                    cy_d  = dcarry;
                    dig_d = dig_q + 2'd1;
                    if (dig_q == 2'd3) begin
                        // Overflow past the ceiling ends the event early.
                        if (dcarry || (acc_sum > SAT_VALUE)) begin
                            acc_d   = SAT_VALUE;
                            state_d = COMMIT;
                        end else if (rep_q == 4'd0) begin
                            state_d = COMMIT;
                        end else begin
                            rep_d = rep_q - 4'd1;
                            dig_d = 2'd0;
                            cy_d  = 1'b0;
                        end
                    end
                end
                COMMIT: begin
                    score_d = acc_q;
                    sat_d   = (acc_q == SAT_VALUE);
                    upd_d   = 1'b1;
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            pts_q   <= 16'h0000;
            rep_q   <= 4'd0;
            acc_q   <= 16'h0000;
            dig_q   <= 2'd0;
            cy_q    <= 1'b0;
            score_q <= 16'h0000;
            upd_q   <= 1'b0;
            sat_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pts_q   <= pts_d;
            rep_q   <= rep_d;
            acc_q   <= acc_d;
            dig_q   <= dig_d;
            cy_q    <= cy_d;
            score_q <= score_d;
            upd_q   <= upd_d;
            sat_q   <= sat_d;
        end
    end

endmodule

// File: tb/tb_score_bcd_counter.sv
// tb/tb_score_bcd_counter.sv - directed self-checking bench for score_bcd_counter
module tb_score_bcd_counter;

    logic        clk;
    logic        rst;
    logic        new_game;
    logic        add_valid;
    logic [2:0]  add_lines;
    logic [3:0]  level;
    logic        add_ready;
    logic [15:0] score_out;
    logic        score_upd;
    logic        saturated;

    int total;
    int bad;

    score_bcd_counter #(.SAT_VALUE(16'h9999)) dut (
        .clk       (clk),
        .rst       (rst),
        .new_game  (new_game),
        .add_valid (add_valid),
        .add_lines (add_lines),
        .level     (level),
        .add_ready (add_ready),
        .score_out (score_out),
        .score_upd (score_upd),
        .saturated (saturated)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issues one event (called at a negedge), then watches max_edges edges.
    // commit_edge is the edge index (E0 = acceptance) after which score_upd
    // is first seen, or -1; ready_bad counts add_ready-high samples before it.
    task automatic run_event(input logic [2:0] lines, input logic [3:0] lvl, input int max_edges,
                             output int commit_edge, output int pulses, output int ready_bad);
        commit_edge = -1;
        pulses      = 0;
        ready_bad   = 0;
        add_valid   = 1'b1;
        add_lines   = lines;
        level       = lvl;
        @(posedge clk);
        @(negedge clk);
        add_valid = 1'b0;
        for (int n = 1; n <= max_edges; n++) begin
            @(posedge clk);
            @(negedge clk);
            if (score_upd) begin
                pulses++;
                if (commit_edge < 0) commit_edge = n;
            end
            if (commit_edge < 0 && add_ready) ready_bad++;
        end
    endtask

    task automatic do_new_game();
        new_game = 1'b1;
        @(posedge clk);
        @(negedge clk);
        new_game = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++;
        if (score_out !== 16'h0000) begin bad++; $display("FAIL reset_score got=%h want=0000", score_out); end
        total++;
        if (score_upd !== 1'b0) begin bad++; $display("FAIL reset_upd got=%b want=0", score_upd); end
        total++;
        if (saturated !== 1'b0) begin bad++; $display("FAIL reset_sat got=%b want=0", saturated); end
        total++;
        if (add_ready !== 1'b0) begin bad++; $display("FAIL reset_ready_in_rst got=%b want=0", add_ready); end
        rst = 1'b0;
        #1;
        total++;
        if (add_ready !== 1'b1) begin bad++; $display("FAIL reset_ready_after got=%b want=1", add_ready); end
        @(negedge clk);
    endtask

    task automatic test_single();
        int ce, pc, rb;
        run_event(3'd1, 4'd0, 10, ce, pc, rb);
        total++;
        if (ce !== 5) begin bad++; $display("FAIL single_latency got=%0d want=5", ce); end
        total++;
        if (pc !== 1) begin bad++; $display("FAIL single_pulses got=%0d want=1", pc); end
        total++;
        if (score_out !== 16'h0040) begin bad++; $display("FAIL single_score got=%h want=0040", score_out); end
        total++;
        if (saturated !== 1'b0) begin bad++; $display("FAIL single_sat got=%b want=0", saturated); end
    endtask

    task automatic test_multi();
        int ce, pc, rb;
        do_new_game();
        run_event(3'd4, 4'd2, 20, ce, pc, rb);
        total++;
        if (ce !== 13) begin bad++; $display("FAIL multi_latency got=%0d want=13", ce); end
        total++;
        if (score_out !== 16'h3600) begin bad++; $display("FAIL multi_score got=%h want=3600", score_out); end
        total++;
        if (rb !== 0) begin bad++; $display("FAIL multi_ready_busy got=%0d want=0", rb); end
        total++;
        if (pc !== 1) begin bad++; $display("FAIL multi_pulses got=%0d want=1", pc); end
    endtask

    task automatic test_ripple();
        int ce, pc, rb;
        do_new_game();
        run_event(3'd2, 4'd7, 40, ce, pc, rb);
        total++;
        if (ce !== 33 || score_out !== 16'h0800) begin bad++; $display("FAIL ripple_step1 got=%h@%0d want=0800@33", score_out, ce); end
        run_event(3'd1, 4'd3, 22, ce, pc, rb);
        total++;
        if (ce !== 17 || score_out !== 16'h0960) begin bad++; $display("FAIL ripple_step2 got=%h@%0d want=0960@17", score_out, ce); end
        run_event(3'd1, 4'd0, 10, ce, pc, rb);
        total++;
        if (ce !== 5 || score_out !== 16'h1000) begin bad++; $display("FAIL ripple_carry got=%h@%0d want=1000@5", score_out, ce); end
    endtask

    task automatic test_saturation();
        int ce, pc, rb;
        do_new_game();
        run_event(3'd4, 4'd12, 50, ce, pc, rb);
        total++;
        if (ce !== 37) begin bad++; $display("FAIL sat_latency got=%0d want=37", ce); end
        total++;
        if (score_out !== 16'h9999) begin bad++; $display("FAIL sat_score got=%h want=9999", score_out); end
        total++;
        if (saturated !== 1'b1) begin bad++; $display("FAIL sat_flag got=%b want=1", saturated); end
        run_event(3'd1, 4'd0, 10, ce, pc, rb);
        total++;
        if (ce !== 5 || pc !== 1) begin bad++; $display("FAIL sat_again_pulse got=%0d@%0d want=1@5", pc, ce); end
        total++;
        if (score_out !== 16'h9999 || saturated !== 1'b1) begin bad++; $display("FAIL sat_again_hold got=%h/%b want=9999/1", score_out, saturated); end
    endtask

    task automatic test_new_game_abort();
        int ce, pc, rb;
        int late;
        do_new_game();
        total++;
        if (score_out !== 16'h0000 || saturated !== 1'b0 || score_upd !== 1'b1) begin
            bad++; $display("FAIL ng_clear got=%h/%b/%b want=0000/0/1", score_out, saturated, score_upd);
        end
        run_event(3'd1, 4'd0, 10, ce, pc, rb);
        add_valid = 1'b1;
        add_lines = 3'd1;
        level     = 4'd0;
        @(posedge clk);
        @(negedge clk);
        add_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        new_game = 1'b1;
        @(posedge clk);
        @(negedge clk);
        new_game = 1'b0;
        total++;
        if (score_out !== 16'h0000 || score_upd !== 1'b1) begin
            bad++; $display("FAIL ng_abort got=%h/%b want=0000/1", score_out, score_upd);
        end
        late = 0;
        for (int n = 0; n < 15; n++) begin
            @(posedge clk);
            @(negedge clk);
            if (score_upd || score_out !== 16'h0000) late++;
        end
        total++;
        if (late !== 0) begin bad++; $display("FAIL ng_no_late_commit got=%0d want=0", late); end

        new_game  = 1'b1;
        add_valid = 1'b1;
        add_lines = 3'd4;
        level     = 4'd0;
        #1;
        total++;
        if (add_ready !== 1'b0) begin bad++; $display("FAIL ng_ready_low got=%b want=0", add_ready); end
        @(posedge clk);
        @(negedge clk);
        new_game  = 1'b0;
        add_valid = 1'b0;
        late = 0;
        for (int n = 0; n < 10; n++) begin
            @(posedge clk);
            @(negedge clk);
            if (score_upd || score_out !== 16'h0000) late++;
        end
        total++;
        if (late !== 0) begin bad++; $display("FAIL ng_same_cycle_ignored got=%0d want=0", late); end
    endtask

    task automatic test_invalid();
        int ce, pc, rb;
        logic [2:0] bad_lines [2];
        int events;
        bad_lines[0] = 3'd0;
        bad_lines[1] = 3'd5;
        run_event(3'd1, 4'd0, 10, ce, pc, rb);
        for (int k = 0; k < 2; k++) begin
            events = 0;
            add_valid = 1'b1;
            add_lines = bad_lines[k];
            level     = 4'd3;
            @(posedge clk);
            @(negedge clk);
            add_valid = 1'b0;
            for (int n = 0; n < 10; n++) begin
                if (score_upd || !add_ready || score_out !== 16'h0040) events++;
                @(posedge clk);
                @(negedge clk);
            end
            total++;
            if (events !== 0) begin bad++; $display("FAIL invalid_lines_%0d got=%0d want=0", bad_lines[k], events); end
        end
    endtask

    task automatic test_back_to_back();
        int first, second;
        first  = -1;
        second = -1;
        do_new_game();
        add_valid = 1'b1;
        add_lines = 3'd1;
        level     = 4'd0;
        @(posedge clk);
        @(negedge clk);
        for (int n = 1; n <= 16; n++) begin
            @(posedge clk);
            @(negedge clk);
            if (n == 6) add_valid = 1'b0;
            if (score_upd) begin
                if (first < 0) first = n;
                else if (second < 0) second = n;
            end
        end
        total++;
        if (first !== 5 || second !== 11) begin bad++; $display("FAIL b2b_timing got=%0d,%0d want=5,11", first, second); end
        total++;
        if (score_out !== 16'h0080) begin bad++; $display("FAIL b2b_score got=%h want=0080", score_out); end
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        rst       = 1'b1;
        new_game  = 1'b0;
        add_valid = 1'b0;
        add_lines = 3'd0;
        level     = 4'd0;
        test_reset();
        test_single();
        test_multi();
        test_ripple();
        test_saturation();
        test_new_game_abort();
        test_invalid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
